viterbi_decision_out: RTL and testbench

Final decision and output stage of the Viterbi decoder. It sits directly downstream of the second butterfly stage. It accepts that stage's two end path metrics (END_00, END_11) and its two 6-bit survivor symbol histories (temp_c00, temp_c11), and selects the survivor with the smaller signed metric. It then maps each 2-bit coded symbol to one decoded bit and streams the 3 decoded bits out serially over a valid/ready handshake, while keeping frame and symbol-error statistics.

---
 rtl/viterbi_decision_out.sv | 146 ++++++++++++++
 tb/tb_viterbi_decision_out.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decision_out.sv
// viterbi_decision_out
// Final survivor selection and serial bit output of the Viterbi decoder.
// A captured trellis result is resolved in one SEL cycle (smaller signed
// metric wins, ties to path 00), then its three coded symbols are emitted
// one decoded bit at a time over a valid/ready handshake. Frame and
// symbol-error counters track completed frames.
module viterbi_decision_out (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] END_00,
  input  logic [7:0] END_11,
  input  logic [5:0] temp_c00,
  input  logic [5:0] temp_c11,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       sym_err,
  output logic [7:0] best_metric,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SEL, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  e00_q, e00_d;
  logic [7:0]  e11_q, e11_d;
  logic [5:0]  c00_q, c00_d;
  logic [5:0]  c11_q, c11_d;
  logic [5:0]  sreg_q, sreg_d;
  logic [1:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [7:0]  best_q, best_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [7:0]  ecnt_q, ecnt_d;

  logic        sel11;
  logic [5:0]  sel_hist;

  // A symbol pair of 01 or 10 is not a legal code word for either branch.
  function automatic logic pair_bad(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

  // Decoded bit: 11->1, 00->0, and the ambiguous pairs take the first coded bit.
  function automatic logic pair_bit(input logic [1:0] p);
    return p[1];
  endfunction

  assign sel11    = $signed(e11_q) < $signed(e00_q);
  assign sel_hist = sel11 ? c11_q : c00_q;

  // Outputs decode straight from state; in_ready is held low while reset is asserted.
  assign in_ready    = RST_N && (state_q == IDLE);
  assign out_valid   = (state_q == SHIFT);
  assign out_bit     = out_valid && pair_bit(sreg_q[5:4]);
  assign out_last    = out_valid && (idx_q == 2'd2);
  assign sym_err     = err_q;
  assign best_metric = best_q;
  assign frame_cnt   = fcnt_q;
  assign err_cnt     = ecnt_q;

  // Next-state and datapath updates for capture, select and shift-out.
  always_comb begin
    state_d = state_q;
    e00_d   = e00_q;
    e11_d   = e11_q;
    c00_d   = c00_q;
    c11_d   = c11_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    err_d   = err_q;
    best_d  = best_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          e00_d   = END_00;
          e11_d   = END_11;
          c00_d   = temp_c00;
          c11_d   = temp_c11;
          state_d = SEL;
        end
      end
      SEL: begin
        sreg_d  = sel_hist;
        best_d  = sel11 ? e11_q : e00_q;
        err_d   = pair_bad(sel_hist[5:4]) | pair_bad(sel_hist[3:2]) |
                  pair_bad(sel_hist[1:0]);
        idx_d   = 2'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Nothing moves until the consumer takes the bit, so a stall holds
        // out_bit, out_last and the index.
        if (out_ready) begin
          sreg_d = {sreg_q[3:0], 2'b00};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            fcnt_d  = fcnt_q + 8'd1;
            if (err_q && (ecnt_q != 8'hFF))
              ecnt_d = ecnt_q + 8'd1;
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any frame in flight and clears the statistics.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      e00_q   <= '0;
      e11_q   <= '0;
      c00_q   <= '0;
      c11_q   <= '0;
      sreg_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      best_q  <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      e00_q   <= e00_d;
      e11_q   <= e11_d;
      c00_q   <= c00_d;
      c11_q   <= c11_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      best_q  <= best_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_viterbi_decision_out.sv
// Scoreboard bench for viterbi_decision_out: stimulus pushes the expected
// bit stream, a negedge monitor pops and compares on each accepted bit.
module tb_viterbi_decision_out;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       in_valid, in_ready;
  logic [7:0] END_00, END_11;
  logic [5:0] temp_c00, temp_c11;
  logic       out_valid, out_ready, out_bit, out_last, sym_err;
  logic [7:0] best_metric, frame_cnt, err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       b;
    logic       l;
    logic       e;
    logic [7:0] m;
  } exp_t;

  exp_t sb[$];

  viterbi_decision_out dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .END_00(END_00), .END_11(END_11), .temp_c00(temp_c00), .temp_c11(temp_c11),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .sym_err(sym_err), .best_metric(best_metric),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected bits are given oldest first in bits[2].
  task automatic push3(input logic [2:0] bits, input logic e, input logic [7:0] m);
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      x.b = bits[2-i];
      x.l = (i == 2);
      x.e = e;
      x.m = m;
      sb.push_back(x);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] c0, input logic [5:0] c1);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 50) begin @(negedge CLK); n++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    END_00 = a; END_11 = b; temp_c00 = c0; temp_c11 = c1;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 50) begin @(negedge CLK); n++; end
    if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge CLK);
    while (!out_valid && n < 50) begin @(negedge CLK); n++; end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Monitor: every accepted bit must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected got bit=%0b exp=none at %0t", out_bit, $time);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("mon_bit",    32'(out_bit),     32'(x.b));
        chk("mon_last",   32'(out_last),    32'(x.l));
        chk("mon_symerr", 32'(sym_err),     32'(x.e));
        chk("mon_metric", 32'(best_metric), 32'(x.m));
      end
    end
  end

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    END_00 = '0; END_11 = '0; temp_c00 = '0; temp_c11 = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bit", 32'(out_bit), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sym_err", 32'(sym_err), 32'd0);
    chk("rst_best", 32'(best_metric), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic path 11: -16 beats 16, history 11 00 11 -> 1 0 1
    push3(3'b101, 1'b0, 8'hF0);
    send(8'h10, 8'hF0, 6'b000000, 6'b110011);
    @(negedge CLK);
    chk("lat_sel_valid", 32'(out_valid), 32'd0);
    chk("lat_sel_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    chk("lat_b0_valid", 32'(out_valid), 32'd1);
    chk("lat_b0_symerr", 32'(sym_err), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    chk("lat_b2_last", 32'(out_last), 32'd1);
    @(negedge CLK);
    chk("lat_idle_ready", 32'(in_ready), 32'd1);
    chk("basic_fcnt", 32'(frame_cnt), 32'd1);
    chk("basic_best", 32'(best_metric), 32'hF0);

    // Tie goes to path 00: 00 00 11 -> 0 0 1
    push3(3'b001, 1'b0, 8'h05);
    send(8'h05, 8'h05, 6'b000011, 6'b111111);
    wait_idle();
    chk("tie_fcnt", 32'(frame_cnt), 32'd2);

    // Signed compare: -128 < 127, path 00: 11 11 00 -> 1 1 0
    push3(3'b110, 1'b0, 8'h80);
    send(8'h80, 8'h7F, 6'b111100, 6'b000000);
    wait_idle();
    chk("sign_best", 32'(best_metric), 32'h80);

    // Back-pressure at bit 1 with an ignored in_valid pulse: 00 11 00 -> 0 1 0
    push3(3'b010, 1'b0, 8'h00);
    send(8'h00, 8'h01, 6'b001100, 6'b111111);
    wait_valid();
    @(posedge CLK); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; END_00 = 8'h7F; END_11 = 8'h80; temp_c11 = 6'b101010;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_bit", 32'(out_bit), 32'd1);
      chk("bp_last", 32'(out_last), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    wait_idle();
    chk("bp_fcnt", 32'(frame_cnt), 32'd4);
    repeat (3) @(negedge CLK);
    chk("bp_nocap_valid", 32'(out_valid), 32'd0);
    chk("bp_nocap_best", 32'(best_metric), 32'h00);

    // Symbol error on path 00: 10 01 00 -> 1 0 0
    push3(3'b100, 1'b1, 8'h01);
    send(8'h01, 8'h02, 6'b100100, 6'b000000);
    wait_idle();
    chk("err_ecnt", 32'(err_cnt), 32'd1);
    chk("err_fcnt", 32'(frame_cnt), 32'd5);
    chk("err_cleared", 32'(sym_err), 32'd0);

    // Reset after bit 1 of a frame: drop it, all state back to reset values
    push3(3'b101, 1'b0, 8'h00);
    send(8'h00, 8'h01, 6'b110011, 6'b000000);
    wait_valid();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mrst_ecnt", 32'(err_cnt), 32'd0);
    sb.delete();
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("mrst_rel_ready", 32'(in_ready), 32'd1);
    chk("mrst_rel_valid", 32'(out_valid), 32'd0);

    // 256 error frames on path 11: 01 10 01 -> 0 1 0
    for (int i = 0; i < 256; i++) begin
      push3(3'b010, 1'b1, 8'hFE);
      send(8'h03, 8'hFE, 6'b000000, 6'b011001);
      wait_idle();
      if (i == 254) begin
        chk("sat_fcnt_255", 32'(frame_cnt), 32'd255);
        chk("sat_ecnt_255", 32'(err_cnt), 32'd255);
      end
    end
    chk("wrap_fcnt", 32'(frame_cnt), 32'd0);
    chk("sat_ecnt", 32'(err_cnt), 32'd255);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
